// File: rtl/breathe_pkg.sv
// rtl/breathe_pkg.sv - shared encodings and width helper for the breathe-LED scheduler
package breathe_pkg;

  // Mode encodings; 2'b11 is folded into chase when start is accepted.
  localparam logic [1:0] MODE_CHASE    = 2'b00;
  localparam logic [1:0] MODE_ALL      = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  // Scheduler state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Ceiling log2, used for counter widths.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/breathe_gap_timer.sv
// rtl/breathe_gap_timer.sv - millisecond prescaler plus gap counter with a one-clock expiry pulse
//
// Ports:
//   clk_i      system clock
//   rst_ni     synchronous active-low reset
//   load_i     restart the timer (prescaler and ms count cleared)
//   gap_ms_i   gap length in milliseconds
//   expired_o  high for the one clock on which the gap ends
module breathe_gap_timer
  import breathe_pkg::*;
#(
  parameter int CLK_PER_MS = 50000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [9:0] gap_ms_i,
  output logic       expired_o
);

  localparam int PW = (clog2(CLK_PER_MS) < 1) ? 1 : clog2(CLK_PER_MS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_MS - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [9:0]    ms_q, ms_d;
  logic          active_q, active_d;
  logic          ms_tick;

  // After a load on edge e, expired_o is high during the clock that ends at
  // edge e + gap_ms*CLK_PER_MS; a zero gap expires on the very next edge.
  always_comb begin
    ms_tick   = (presc_q == PRESC_LAST);
    expired_o = active_q &&
                ((gap_ms_i == 10'd0) || (ms_tick && (ms_q == gap_ms_i - 10'd1)));
    presc_d   = presc_q;
    ms_d      = ms_q;
    active_d  = active_q;
    if (load_i) begin
      presc_d  = '0;
      ms_d     = '0;
      active_d = 1'b1;
    end else if (expired_o) begin
      presc_d  = '0;
      ms_d     = '0;
      active_d = 1'b0;
    end else if (active_q) begin
      if (ms_tick) begin
        presc_d = '0;
        ms_d    = ms_q + 10'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      presc_q  <= '0;
      ms_q     <= '0;
      active_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      ms_q     <= ms_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/breathe_led_scheduler.sv
// rtl/breathe_led_scheduler.sv - sequences breathe-LED channels in chase, all-together or ping-pong order
//
// Ports:
//   sys_clk     system clock
//   sys_rst_n   synchronous active-low reset
//   start       pulse: begin sequencing from IDLE (mode sampled here)
//   stop        pulse: abort to IDLE, wins over everything else
//   mode        00 chase, 01 all-together, 10 ping-pong, 11 chase
//   cycle_done  per-channel end-of-breath pulses
//   ch_en       registered enable to each breathe instance
//   cur_ch      active channel index (0 in all-together mode)
//   busy        high in RUN or GAP
//   round_done  one-clock pulse when a full round ends
module breathe_led_scheduler
  import breathe_pkg::*;
#(
  parameter int NUM_CH        = 3,
  parameter int CYCLES_PER_CH = 4,
  parameter int CLK_PER_MS    = 50000,
  parameter int GAP_MS        = 200
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [NUM_CH-1:0] cycle_done,
  output logic [NUM_CH-1:0] ch_en,
  output logic [2:0]        cur_ch,
  output logic              busy,
  output logic              round_done
);

  localparam logic [2:0] LAST_CH  = 3'(NUM_CH - 1);
  localparam logic [7:0] CNT_LAST = 8'(CYCLES_PER_CH - 1);

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [2:0]        cur_q, cur_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              dir_up_q, dir_up_d;
  logic              first_q, first_d;
  logic [NUM_CH-1:0] en_q, en_d;
  logic              rd_q, rd_d;

  logic [7:0] cd_ext;
  logic       hit;
  logic       leaving_end;
  logic [2:0] next_ch;
  logic       next_dir_up;
  logic       gap_load;
  logic       gap_expired;

  breathe_gap_timer #(
    .CLK_PER_MS(CLK_PER_MS)
  ) u_gap_timer (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .load_i   (gap_load),
    .gap_ms_i (10'(GAP_MS)),
    .expired_o(gap_expired)
  );

  always_comb begin
    cd_ext = 8'(cycle_done);
    // All-together mode breathes in lockstep, so channel 0 paces the turn.
    hit = (mode_q == MODE_ALL) ? cd_ext[0] : cd_ext[cur_q];

    next_ch     = cur_q;
    next_dir_up = dir_up_q;
    leaving_end = 1'b0;
    case (mode_q)
      MODE_ALL: begin
        next_ch     = 3'd0;
        leaving_end = 1'b1;
      end
      MODE_PINGPONG: begin
        // Direction flips on the turnaround itself, so the end channel is not repeated.
        if (dir_up_q) begin
          if (cur_q == LAST_CH) begin
            next_ch     = cur_q - 3'd1;
            next_dir_up = 1'b0;
          end else begin
            next_ch = cur_q + 3'd1;
          end
        end else begin
          if (cur_q == 3'd0) begin
            next_ch     = 3'd1;
            next_dir_up = 1'b1;
          end else begin
            next_ch = cur_q - 3'd1;
          end
        end
        // The opening turn on channel 0 is not the end of a round.
        leaving_end = ((cur_q == LAST_CH) || (cur_q == 3'd0)) && !first_q;
      end
      default: begin
        next_ch     = (cur_q == LAST_CH) ? 3'd0 : cur_q + 3'd1;
        leaving_end = (cur_q == LAST_CH);
      end
    endcase

    state_d  = state_q;
    mode_d   = mode_q;
    cur_d    = cur_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    first_d  = first_q;
    en_d     = en_q;
    rd_d     = 1'b0;
    gap_load = 1'b0;

    if (stop) begin
      state_d = ST_IDLE;
      en_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d  = ST_RUN;
            mode_d   = ((mode == MODE_ALL) || (mode == MODE_PINGPONG)) ? mode : MODE_CHASE;
            cur_d    = 3'd0;
            cnt_d    = '0;
            dir_up_d = 1'b1;
            first_d  = 1'b1;
            en_d     = (mode == MODE_ALL) ? '1 : NUM_CH'(1);
          end
        end
        ST_RUN: begin
          if (hit) begin
            if (cnt_q == CNT_LAST) begin
              state_d  = ST_GAP;
              cnt_d    = '0;
              en_d     = '0;
              gap_load = 1'b1;
              rd_d     = leaving_end;
              first_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ST_GAP: begin
          if (gap_expired) begin
            state_d  = ST_RUN;
            cur_d    = next_ch;
            dir_up_d = next_dir_up;
            en_d     = (mode_q == MODE_ALL) ? '1 : (NUM_CH'(1) << next_ch);
          end
        end
        default: begin
          state_d = ST_IDLE;
          en_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_CHASE;
      cur_q    <= '0;
      cnt_q    <= '0;
      dir_up_q <= 1'b0;
      first_q  <= 1'b0;
      en_q     <= '0;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cur_q    <= cur_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
      first_q  <= first_d;
      en_q     <= en_d;
      rd_q     <= rd_d;
    end
  end

  assign ch_en      = en_q;
  assign cur_ch     = cur_q;
  assign busy       = (state_q != ST_IDLE);
  assign round_done = rd_q;

endmodule

// File: tb/tb_breathe_led_scheduler.sv
// tb/tb_breathe_led_scheduler.sv - scoreboard bench for breathe_led_scheduler
module tb_breathe_led_scheduler;

  localparam int NCH     = 3;
  localparam int CYC     = 2;
  localparam int CPM     = 4;
  localparam int GMS     = 2;
  localparam int GAP_CLK = GMS * CPM;
  localparam int BUDGET  = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [2:0] cd = 3'b000;
  logic [2:0] ch_en, cur_ch;
  logic       busy, round_done;

  logic       start_z = 1'b0, stop_z = 1'b0;
  logic [2:0] cd_z = 3'b000;
  logic [2:0] ch_en_z, cur_ch_z;
  logic       busy_z, round_done_z;

  always #5 clk = ~clk;

  breathe_led_scheduler #(
    .NUM_CH(NCH), .CYCLES_PER_CH(CYC), .CLK_PER_MS(CPM), .GAP_MS(GMS)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .cycle_done(cd), .ch_en(ch_en), .cur_ch(cur_ch), .busy(busy), .round_done(round_done)
  );

  breathe_led_scheduler #(
    .NUM_CH(NCH), .CYCLES_PER_CH(CYC), .CLK_PER_MS(CPM), .GAP_MS(0)
  ) dut_z (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start_z), .stop(stop_z), .mode(2'b00),
    .cycle_done(cd_z), .ch_en(ch_en_z), .cur_ch(cur_ch_z), .busy(busy_z), .round_done(round_done_z)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] en;
    int         cur;
    int         dark;
  } turn_t;

  turn_t turn_q[$];
  bit    rd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: channel visited on turn k of a sequence, from the mode's rule.
  function automatic int m_ch(input logic [1:0] md, input int k);
    int p;
    if (md == 2'b01) return 0;
    if (md == 2'b10) begin
      p = k % (2 * NCH - 2);
      return (p < NCH) ? p : (2 * NCH - 2 - p);
    end
    return k % NCH;
  endfunction

  function automatic logic [2:0] m_en(input logic [1:0] md, input int k);
    if (md == 2'b01) return 3'b111;
    return 3'(1 << m_ch(md, k));
  endfunction

  // Round ends when leaving turn k.
  function automatic bit m_rd(input logic [1:0] md, input int k);
    int c;
    c = m_ch(md, k);
    if (md == 2'b01) return 1'b1;
    if (md == 2'b10) return (k > 0) && ((c == 0) || (c == NCH - 1));
    return c == NCH - 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input bit want_nz, input string name);
    int n;
    n = 0;
    while (((ch_en != 3'b000) != want_nz) && (n < BUDGET)) begin
      tick();
      n++;
    end
    if (n >= BUDGET) chk({name, " timeout"}, 32'd0, 32'd1);
  endtask

  task automatic push_turn(input logic [1:0] md, input int k, input int dark);
    turn_t t;
    t.en   = m_en(md, k);
    t.cur  = m_ch(md, k);
    t.dark = dark;
    turn_q.push_back(t);
  endtask

  // Runs nturns channel turns; the last turn's final pulse coincides with stop.
  task automatic run_seq(input logic [1:0] md_in, input int nturns);
    logic [1:0] md;
    logic [2:0] act, noise;
    md = (md_in == 2'b11) ? 2'b00 : md_in;
    push_turn(md, 0, 0);
    mode  = md_in;
    start = 1'b1;
    tick();
    start = 1'b0;
    mode  = 2'($urandom);
    chk("busy after start", busy, 1);
    chk("ch_en after start", ch_en, m_en(md, 0));
    for (int k = 0; k < nturns; k++) begin
      wait_en(1'b1, "turn start");
      act = (md == 2'b01) ? 3'b001 : 3'(1 << m_ch(md, k));
      for (int p = 0; p < CYC; p++) begin
        repeat ($urandom_range(0, 3)) tick();
        noise = 3'($urandom) & ~act;
        if (noise != 3'b000) begin
          cd    = noise;
          start = 1'($urandom);
          mode  = 2'($urandom);
          tick();
          cd    = 3'b000;
          start = 1'b0;
        end
        if (p == CYC - 1) begin
          if (k == nturns - 1) begin
            stop = 1'b1;
          end else begin
            rd_q.push_back(m_rd(md, k));
            push_turn(md, k + 1, GAP_CLK);
          end
        end
        cd = act;
        tick();
        cd = 3'b000;
        if (stop) begin
          stop = 1'b0;
          chk("ch_en after stop", ch_en, 0);
          chk("busy after stop", busy, 0);
          chk("round_done after stop", round_done, 0);
        end
      end
      if (k != nturns - 1) wait_en(1'b0, "gap entry");
    end
    tick();
  endtask

  // Monitor: compares DUT turn starts and gap entries against the scoreboard queues.
  initial begin : monitor
    logic [2:0] prev_en;
    int         dark;
    turn_t      t;
    bit         rd;
    prev_en = 3'b000;
    dark    = 0;
    forever begin
      @(negedge clk);
      if (!busy) dark = 0;
      else if (ch_en == 3'b000) dark++;
      if ((prev_en != 3'b000) && (ch_en == 3'b000) && busy) begin
        if (rd_q.size() == 0) begin
          chk("unexpected gap entry", 32'd1, 32'd0);
        end else begin
          rd = rd_q.pop_front();
          chk("round_done at gap entry", round_done, rd);
        end
      end else if (round_done) begin
        chk("stray round_done", 32'd1, 32'd0);
      end
      if ((prev_en == 3'b000) && (ch_en != 3'b000)) begin
        if (turn_q.size() == 0) begin
          chk("unexpected turn ch_en", ch_en, 0);
        end else begin
          t = turn_q.pop_front();
          chk("turn ch_en", ch_en, t.en);
          chk("turn cur_ch", cur_ch, t.cur);
          chk("dark clocks before turn", dark, t.dark);
        end
        dark = 0;
      end
      prev_en = ch_en;
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset ch_en", ch_en, 0);
    chk("reset cur_ch", cur_ch, 0);
    chk("reset busy", busy, 0);
    chk("reset round_done", round_done, 0);
    chk("reset z ch_en", ch_en_z, 0);
    rst_n = 1'b1;
    tick();

    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    tick();
    chk("start+stop busy", busy, 0);
    chk("start+stop ch_en", ch_en, 0);

    run_seq(2'b00, 7);
    run_seq(2'b10, 7);
    run_seq(2'b01, 3);
    run_seq(2'b11, 4);
    for (int r = 0; r < 3; r++) run_seq(2'($urandom_range(0, 3)), $urandom_range(1, 6));

    // Reset while in the dark gap.
    push_turn(2'b00, 0, 0);
    mode  = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_en(1'b1, "rst seq turn");
    cd = 3'b001; tick(); cd = 3'b000; tick();
    rd_q.push_back(m_rd(2'b00, 0));
    cd = 3'b001; tick(); cd = 3'b000;
    wait_en(1'b0, "rst seq gap");
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid-gap reset ch_en", ch_en, 0);
    chk("mid-gap reset busy", busy, 0);
    chk("mid-gap reset cur_ch", cur_ch, 0);
    chk("mid-gap reset round_done", round_done, 0);
    repeat (GAP_CLK + 4) tick();
    chk("idle after reset ch_en", ch_en, 0);
    run_seq(2'b00, 2);

    // Zero-length gap on the second instance.
    start_z = 1'b1;
    tick();
    start_z = 1'b0;
    chk("gap0 first ch_en", ch_en_z, 3'b001);
    cd_z = 3'b001; tick(); cd_z = 3'b000; tick();
    cd_z = 3'b001; tick(); cd_z = 3'b000;
    chk("gap0 dark ch_en", ch_en_z, 0);
    chk("gap0 dark busy", busy_z, 1);
    chk("gap0 round_done", round_done_z, 0);
    tick();
    chk("gap0 next ch_en", ch_en_z, 3'b010);
    chk("gap0 next cur_ch", cur_ch_z, 1);
    stop_z = 1'b1;
    tick();
    stop_z = 1'b0;
    chk("gap0 stop busy", busy_z, 0);

    repeat (3) tick();
    chk("turn queue drained", turn_q.size(), 0);
    chk("round queue drained", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
